// File: rtl/line_window_pkg.sv
// Shared types and default geometry for the sliding-window line-buffer controller.
package line_window_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_e;

  localparam int DEF_IMG_W  = 1920;
  localparam int DEF_IMG_H  = 1080;
  localparam int DEF_KERNEL = 3;

  function automatic int calc_half(input int kernel);
    return (kernel - 1) / 2;
  endfunction

  // Row counter must reach IMG_H+HALF so the flush rows can be tracked past the last input row.
  function automatic int row_cnt_w(input int img_h, input int kernel);
    return $clog2(img_h + calc_half(kernel) + 1);
  endfunction

  localparam int DEF_HALF  = calc_half(DEF_KERNEL);
  localparam int DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int DEF_ROW_W = row_cnt_w(DEF_IMG_H, DEF_KERNEL);

endpackage

// File: rtl/line_window_ctrl_raster_counter.sv
// Raster column/row position tracker with end-of-line resync and line-length error detection.
module raster_counter
  import line_window_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int CW    = DEF_COL_W,
  parameter int RW    = DEF_ROW_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          restart,
  input  logic          chk,
  input  logic          eol,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] cur_row,
  output logic [RW-1:0] row_step,
  output logic          err
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] col_q, col_d, col_step;
  logic [RW-1:0] row_q, row_d;
  logic          last, eol_early, eol_miss, wrap;

  // A restarting pixel is treated as (0,0) regardless of where the counters stood.
  always_comb begin
    cur_col   = restart ? '0 : col_q;
    cur_row   = restart ? '0 : row_q;
    last      = (cur_col == COL_LAST);
    eol_early = chk & eol & ~last;
    eol_miss  = chk & ~eol & last;
    wrap      = last | eol_early;
    col_step  = col_q;
    row_step  = row_q;
    if (adv) begin
      col_step = wrap ? '0 : cur_col + COL_ONE;
      row_step = wrap ? cur_row + ROW_ONE : cur_row;
    end
    err = adv & (eol_early | eol_miss);
  end

  always_comb begin
    col_d = clr ? '0 : col_step;
    row_d = clr ? '0 : row_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Sequencer for a KERNEL-1 line-buffer cascade: prime, run, flush, window-centre coordinates and borders.
// Optional macro LINE_WINDOW_CTRL_ERR_CNT_EN adds err_cnt (saturating) and frame_cnt (wrapping) outputs.
module line_window_ctrl
  import line_window_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int KERNEL = DEF_KERNEL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_sof,
  input  logic                     s_eol,
  output logic                     lb_ena,
  output logic                     lb_pad,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     win_top,
  output logic                     win_bot,
  output logic                     win_left,
  output logic                     win_right,
  output logic                     frame_done,
  output logic                     err_len
`ifdef LINE_WINDOW_CTRL_ERR_CNT_EN
  ,
  output logic [15:0]              err_cnt,
  output logic [15:0]              frame_cnt
`endif
);

  localparam int HALF = calc_half(KERNEL);
  localparam int CW   = $clog2(IMG_W);
  localparam int WRW  = $clog2(IMG_H);
  localparam int RW   = row_cnt_w(IMG_H, KERNEL);

  localparam logic [RW-1:0] ROW_HALF  = RW'(HALF);
  localparam logic [RW-1:0] ROW_2HALF = RW'(2 * HALF);
  localparam logic [RW-1:0] ROW_H     = RW'(IMG_H);
  localparam logic [RW-1:0] ROW_END   = RW'(IMG_H + HALF);
  localparam logic [CW-1:0] COL_LEFT  = CW'(HALF);
  localparam logic [CW-1:0] COL_RIGHT = CW'(IMG_W - HALF);

  state_e         state_q, state_d, cnt_state;
  logic           accept, adv, restart, chk, clr, cnt_err;
  logic [CW-1:0]  cur_col;
  logic [RW-1:0]  cur_row, row_step;
  logic           win_valid_q, win_valid_d, frame_done_q, frame_done_d, err_len_q, err_len_d;
  logic [WRW-1:0] win_row_q, win_row_d;
  logic [CW-1:0]  win_col_q, win_col_d;
  logic           top_q, top_d, bot_q, bot_d, left_q, left_d, right_q, right_d;

  assign s_ready = (state_q != FLUSH);
  assign lb_pad  = (state_q == FLUSH);
  assign accept  = s_valid & s_ready;
  // Pixels arriving in IDLE only count once they carry start-of-frame.
  assign adv     = (state_q == FLUSH) | (accept & ((state_q != IDLE) | s_sof));
  assign restart = accept & s_sof;
  assign chk     = (state_q != FLUSH);
  assign lb_ena  = adv;

  raster_counter #(.IMG_W(IMG_W), .CW(CW), .RW(RW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .adv      (adv),
    .restart  (restart),
    .chk      (chk),
    .eol      (s_eol),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .row_step (row_step),
    .err      (cnt_err)
  );

  always_comb begin
    cnt_state    = (row_step >= ROW_H) ? FLUSH : (row_step >= ROW_HALF) ? RUN : PRIME;
    state_d      = state_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_len_d    = cnt_err;
    clr          = 1'b0;
    case (state_q)
      IDLE: begin
        if (restart) state_d = cnt_state;
      end
      PRIME, RUN: begin
        if (accept) begin
          win_valid_d = (cur_row >= ROW_HALF);
          if (s_sof) err_len_d = 1'b1;
          state_d = cnt_state;
        end
      end
      FLUSH: begin
        win_valid_d = 1'b1;
        if (row_step == ROW_END) begin
          frame_done_d = 1'b1;
          clr          = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window centre trails the input row by HALF; coordinates hold while no window is issued.
  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    top_d     = top_q;
    bot_d     = bot_q;
    left_d    = left_q;
    right_d   = right_q;
    if (win_valid_d) begin
      win_row_d = WRW'(cur_row - ROW_HALF);
      win_col_d = cur_col;
      top_d     = (cur_row < ROW_2HALF);
      bot_d     = (cur_row >= ROW_H);
      left_d    = (cur_col < COL_LEFT);
      right_d   = (cur_col >= COL_RIGHT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      top_q        <= 1'b0;
      bot_q        <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      left_q       <= left_d;
      right_q      <= right_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign win_top    = top_q;
  assign win_bot    = bot_q;
  assign win_left   = left_q;
  assign win_right  = right_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;

`ifdef LINE_WINDOW_CTRL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d;

  always_comb begin
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (err_len_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    if (frame_done_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Sequences a cascade of KERNEL-1 line_buffer instances for a KERNEL x KERNEL sliding-window filter on a raster pixel stream.
- Generates the shared line-buffer enable and pad strobe, and tracks row/column position.
- Primes the first rows, flushes the last rows with synthetic pad pixels, and reports window-centre coordinates plus border flags to the downstream window/filter stage.
- Sits between the pixel source (valid/ready stream) and the line-buffer chain plus window register.

Parameters:
- IMG_W, 1920, active pixels per line; equals LINE_WIDTH of the controlled line buffers.
- IMG_H, 1080, active lines per frame.
- KERNEL, 3, window size; odd, >= 3. HALF = (KERNEL-1)/2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  controller accepts pixel.
- s_sof  in  1  start of frame; qualified by s_valid.
- s_eol  in  1  last pixel of line; qualified by s_valid.
- lb_ena  out  1  enable to every line_buffer and the window shift register (combinational).
- lb_pad  out  1  high during flush; downstream muxes zero into the chain head.
- win_valid  out  1  window centred on (win_row, win_col) is valid this cycle (registered).
- win_row  out  $clog2(IMG_H)  centre row.
- win_col  out  $clog2(IMG_W)  centre column.
- win_top  out  1  win_row < HALF.
- win_bot  out  1  win_row >= IMG_H-HALF.
- win_left  out  1  win_col < HALF.
- win_right  out  1  win_col >= IMG_W-HALF.
- frame_done  out  1  one-cycle pulse after the last flush pixel.
- err_len  out  1  one-cycle pulse on a line-length or mid-frame SOF error.

Behaviour:
- Reset: state = IDLE. win_valid, frame_done, err_len, lb_pad = 0. All counters = 0. Registered outputs = 0.
- Accept = s_valid & s_ready. lb_ena = accept in PRIME/RUN, 1 in FLUSH, 0 otherwise.
- IDLE:
  - s_ready = 1; pixels without s_sof are discarded with no lb_ena.
  - accept & s_sof: treat the pixel as (row 0, col 0), assert lb_ena, go to PRIME.
- PRIME:
  - Rows 0..HALF-1; s_ready = 1; win_valid stays 0.
  - On completing row HALF-1, go to RUN.
- RUN:
  - s_ready = 1.
  - Each accept at input (row r, col c) produces win_valid = 1 one cycle later, with win_row = r-HALF and win_col = c. This matches the 1-cycle registered line_buffer read.
  - When input row IMG_H-1 completes, go to FLUSH.
- FLUSH:
  - s_ready = 0; lb_pad = 1; lb_ena = 1 every cycle.
  - Runs HALF synthetic rows of IMG_W cycles, reporting win_row = IMG_H-HALF .. IMG_H-1.
  - After the last cycle: frame_done pulses with the final win_valid, then go to IDLE.
- Column counter:
  - Wraps IMG_W-1 -> 0 and increments the row counter.
  - s_eol accepted at col != IMG_W-1: err_len pulses; col forced to 0; row increments (short-line resync).
  - col == IMG_W-1 accepted without s_eol: err_len pulses; wrap proceeds normally.
- s_sof accepted in PRIME/RUN: err_len pulses; counters restart at (0,0) with this pixel; state = PRIME. The partial frame is abandoned with no frame_done.
- s_sof is ignored in FLUSH because s_ready = 0.
- Border flags are registered alongside win_row/win_col and are meaningful only when win_valid = 1.
- rst asserted mid-frame returns to IDLE the next edge. Line-buffer contents are not cleared; priming overwrites them.
- With s_valid low, PRIME/RUN hold all counters; no bubbles are introduced into lb_ena.

Optional Feature:
- Macro LINE_WINDOW_CTRL_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [15:0], counting err_len pulses and saturating at 16'hFFFF.
  - Adds output frame_cnt [15:0], counting frame_done pulses with wrap.
  - Both cleared by rst.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package line_window_pkg holds:
  - state enum {IDLE, PRIME, RUN, FLUSH};
  - HALF and counter-width localparams derived from IMG_W/IMG_H/KERNEL.
- One natural sub-module, raster_counter: col/row counters with wrap, eol resync and error detect. The FSM and output registers stay in the top.

Test Plan:
- IMG_W=8, IMG_H=4, KERNEL=3; one clean frame with s_valid always high → 8 PRIME cycles with no win_valid. Then 24 win_valid in RUN covering rows 0..2, then 8 FLUSH cycles with lb_pad=1 for row 3. frame_done coincides with (win_row 3, win_col 7). Total 32 win_valid.
- Border check on the same frame → win_top only on row 0; win_bot only on row 3; win_left on col 0; win_right on col 7.
- s_valid toggling 50% → identical win_row/win_col sequence to the first test, no lb_ena while s_valid=0, frame_done still after 32 windows.
- s_eol at col 5 of row 1 → err_len pulse one cycle later; next pixel at (row 2, col 0).
- s_sof at row 2 col 3 → err_len pulse; return to PRIME at (0,0); no frame_done for the abandoned frame.
- rst high for 1 cycle during FLUSH → state IDLE, lb_pad=0, s_ready=1. With LINE_WINDOW_CTRL_ERR_CNT_EN, err_cnt=0 after reset and err_cnt=2 after the two error scenarios.
